// File: rtl/aes_sched_pkg.sv
// ---------------------------------------------------------------------------
// aes_sched_pkg
// Shared definitions for the masked-AES job scheduler:
//   - sched_state_t : scheduler FSM states
//   - CHUNKS/CHUNK_W: serial load geometry (16 chunks of 16 bits per 256-bit
//                     two-share operand)
//   - SHARE_W       : width of one share
//   - PRNG_W        : mask randomness width
//   - LFSR_TAPS     : tap mask for x^19 + x^18 + x^17 + x^14 + 1
//   - lfsr_next()   : one Fibonacci shift step
// ---------------------------------------------------------------------------
package aes_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GO,
        ST_LOAD,
        ST_WAIT,
        ST_RESP
    } sched_state_t;

    localparam int CHUNKS  = 16;
    localparam int CHUNK_W = 16;
    localparam int SHARE_W = 128;
    localparam int PRNG_W  = 19;

    // Register bits 18,17,16,13 correspond to the x^19, x^18, x^17, x^14 terms.
    localparam logic [PRNG_W-1:0] LFSR_TAPS = 19'h72000;

    function automatic logic [PRNG_W-1:0] lfsr_next(input logic [PRNG_W-1:0] s);
        return {s[PRNG_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/prng_lfsr19.sv
// ---------------------------------------------------------------------------
// prng_lfsr19
// 19-bit Fibonacci LFSR supplying mask randomness to the AES core. Shifts on
// every clock; a reseed request overrides the shift for that cycle. An
// all-zero seed would lock the LFSR, so it is replaced by SEED.
// Ports:
//   i_clk      : clock, rising edge
//   i_rst_n    : asynchronous active-low reset (loads SEED)
//   i_reseed   : load i_seed this cycle
//   i_seed     : reseed value (0 selects SEED)
//   o_state    : current LFSR register value
// ---------------------------------------------------------------------------
module prng_lfsr19
    import aes_sched_pkg::*;
#(
    parameter logic [PRNG_W-1:0] SEED = 19'h5A5A5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_reseed,
    input  logic [PRNG_W-1:0] i_seed,
    output logic [PRNG_W-1:0] o_state
);

    logic [PRNG_W-1:0] r_state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= SEED;
        end else if (i_reseed) begin
            r_state <= (i_seed == '0) ? SEED : i_seed;
        end else begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/aes_job_scheduler.sv
// ---------------------------------------------------------------------------
// aes_job_scheduler
// Front end for the round-based masked AES core. Arbitrates two requesters
// round-robin, streams the latched two-share plaintext/key into the core in
// 16-bit chunks (MSB chunk first), supplies LFSR mask randomness, and returns
// the two-share ciphertext. A watchdog aborts the job and pulses core_reset
// if the core never signals done.
// Ports:
//   clk, reset            : clock; asynchronous active-low reset
//   req_valid/req_ready   : per-requester job handshake (ready is one-hot)
//   req_pt0/1, req_key0/1 : per-requester {share1, share0} operands
//   resp_valid/resp_ready : response handshake
//   resp_id, resp_err     : owning requester; watchdog abort flag
//   resp_data             : {ct_share1, ct_share0}, 0 on abort
//   reseed_valid, seed_in : LFSR reload
//   core_reset, core_go   : core reset (active high) and start pulse
//   core_pt, core_key     : serial load chunks (0 outside LOAD)
//   core_prng             : mask randomness
//   core_done, core_out   : core result
// ---------------------------------------------------------------------------
module aes_job_scheduler
    import aes_sched_pkg::*;
#(
    parameter int                TIMEOUT = 4095,
    parameter logic [PRNG_W-1:0] SEED    = 19'h5A5A5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [2*SHARE_W-1:0]   req_pt0,
    input  logic [2*SHARE_W-1:0]   req_pt1,
    input  logic [2*SHARE_W-1:0]   req_key0,
    input  logic [2*SHARE_W-1:0]   req_key1,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   resp_id,
    output logic                   resp_err,
    output logic [2*SHARE_W-1:0]   resp_data,
    input  logic                   reseed_valid,
    input  logic [PRNG_W-1:0]      seed_in,
    output logic                   core_reset,
    output logic                   core_go,
    output logic [CHUNK_W-1:0]     core_pt,
    output logic [CHUNK_W-1:0]     core_key,
    output logic [PRNG_W-1:0]      core_prng,
    input  logic                   core_done,
    input  logic [2*SHARE_W-1:0]   core_out
);

    localparam int              WD_W    = 12;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [3:0]      K_LAST  = 4'(CHUNKS - 1);

    sched_state_t         r_state;
    logic                 r_last_grant;
    logic [3:0]           r_chunk;
    logic [WD_W-1:0]      r_wd;
    logic [2*SHARE_W-1:0] r_pt;
    logic [2*SHARE_W-1:0] r_key;
    logic                 r_resp_valid;
    logic                 r_resp_id;
    logic                 r_resp_err;
    logic [2*SHARE_W-1:0] r_resp_data;
    logic                 r_core_reset;
    logic                 r_core_go;

    logic                 w_gnt;
    logic                 w_idle_ok;
    logic [1:0]           w_ready;
    logic                 w_accept;
    logic [7:0]           w_msb;

    // Round-robin: on a tie the port that did not win last time is granted.
    // Accepts are held off while core_reset is high so no job is taken during
    // reset or before the core has left reset.
    always_comb begin
        if (req_valid == 2'b11) begin
            w_gnt = ~r_last_grant;
        end else begin
            w_gnt = req_valid[1];
        end
        w_idle_ok = (r_state == ST_IDLE) && !r_core_reset;
        w_ready   = {w_gnt, ~w_gnt} & req_valid & {2{w_idle_ok}};
    end

    assign w_accept = |w_ready;

    // Operand capture; contents only matter while loading, so no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pt  <= w_gnt ? req_pt1  : req_pt0;
            r_key <= w_gnt ? req_key1 : req_key0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_chunk      <= '0;
            r_wd         <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_data  <= '0;
            r_core_reset <= 1'b1;
            r_core_go    <= 1'b0;
        end else begin
            r_core_go    <= 1'b0;
            r_core_reset <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_last_grant <= w_gnt;
                        r_resp_id    <= w_gnt;
                        r_core_go    <= 1'b1;
                        r_state      <= ST_GO;
                    end
                end
                ST_GO: begin
                    r_chunk <= '0;
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_chunk <= r_chunk + 4'd1;
                    if (r_chunk == K_LAST) begin
                        r_wd    <= '0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // done is checked first so it wins over a coincident timeout
                    if (core_done) begin
                        r_resp_data  <= core_out;
                        r_resp_err   <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end else if (r_wd == WD_LAST) begin
                        r_resp_data  <= '0;
                        r_resp_err   <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_core_reset <= 1'b1;
                        r_state      <= ST_RESP;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Chunk k occupies bits [255-16k -: 16]; 255-16k == {~k, 4'hF}.
    assign w_msb = {~r_chunk, 4'hF};

    always_comb begin
        core_pt  = '0;
        core_key = '0;
        if (r_state == ST_LOAD) begin
            core_pt  = r_pt[w_msb -: CHUNK_W];
            core_key = r_key[w_msb -: CHUNK_W];
        end
    end

    prng_lfsr19 #(
        .SEED (SEED)
    ) u_prng (
        .i_clk    (clk),
        .i_rst_n  (reset),
        .i_reseed (reseed_valid),
        .i_seed   (seed_in),
        .o_state  (core_prng)
    );

    assign req_ready  = w_ready;
    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_err   = r_resp_err;
    assign resp_data  = r_resp_data;
    assign core_reset = r_core_reset;
    assign core_go    = r_core_go;

endmodule

// File: doc/aes_job_scheduler.md
# aes_job_scheduler

Front-end controller for the round-based masked AES core `full_AES`. It accepts encryption jobs from two requesters and arbitrates between them round-robin. It streams each job's two-share plaintext and key into the core over the 16-bit serial load port, supplies fresh mask randomness from an internal LFSR, and returns the two-share ciphertext to the owning requester. It includes a watchdog that recovers the core if `done` never arrives.

## Interface
- `TIMEOUT`, 4095: max cycles in WAIT before abort (12-bit counter).
- `SEED`, 19'h5A5A5: LFSR reset/fallback seed; must be nonzero.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 2: per-requester job valid.
- `req_ready` out 2: per-requester accept; at most one bit high.
- `req_pt0`, `req_pt1` in 2x256: per-requester `{pt_share1, pt_share0}`.
- `req_key0`, `req_key1` in 2x256: per-requester `{key_share1, key_share0}`.
- `resp_valid` out 1, `resp_ready` in 1: response handshake.
- `resp_id` out 1: requester owning the response.
- `resp_err` out 1: job aborted by watchdog.
- `resp_data` out 256: `{ct_share1, ct_share0}`.
- `reseed_valid` in 1, `seed_in` in 19: LFSR reload.
- `core_reset` out 1: active-high reset to `full_AES`.
- `core_go` out 1: start pulse.
- `core_pt`, `core_key` out 16: serial load chunks.
- `core_prng` out 19: mask randomness.
- `core_done` in 1, `core_out` in 256: core result.

## Operation
- FSM states: IDLE -> GO -> LOAD -> WAIT -> RESP -> IDLE.
- IDLE: grant one valid requester.
  - Both valid: grant the port != `last_grant`.
  - `last_grant` resets to 1, so port 0 wins the first tie.
  - `req_ready[g]` is high combinationally in IDLE when `req_valid[g]` is set and g is granted.
  - On handshake: latch pt/key (256 bits each) and id, update `last_grant`, go to GO.
- GO: `core_go`=1 for exactly one cycle.
- LOAD: 16 cycles; 4-bit chunk counter k=0..15.
  - `core_pt` = pt[255-16k -: 16], MSB chunk first; same for `core_key`.
  - After k=15, go to WAIT.
- WAIT: 12-bit watchdog counts from 0.
  - First cycle with `core_done`=1: capture `core_out`, `resp_err`=0, go to RESP.
  - Counter == TIMEOUT-1 with no done: `resp_data`=0, `resp_err`=1, pulse `core_reset` for 1 cycle, go to RESP.
  - If done and the timeout coincide, done wins.
- RESP: hold `resp_valid`, `resp_id`, `resp_err`, `resp_data` stable until `resp_ready`, then return to IDLE.
- Outside LOAD, `core_pt` and `core_key` are 0.
- LFSR: 19-bit Fibonacci, polynomial x^19+x^18+x^17+x^14+1, shifts every cycle in all states; `core_prng` is the register value.
  - `reseed_valid`: load `seed_in`, or SEED if `seed_in`==0.
  - Reseed takes priority over the shift in that cycle.
- `core_reset` is high while `reset` is low (async assert), deasserts synchronously on the first clock after release, and also pulses on timeout.

## Timing
- Reset values: state IDLE, `req_ready`=0, `resp_valid`=0, `resp_err`=0, `resp_id`=0, `resp_data`=0, `core_go`=0, `core_pt`/`core_key`=0, LFSR=SEED, `core_reset`=1.
- Accept on cycle A; `core_go` high on A+1; chunks on A+2..A+17.
- Earliest `resp_valid` is 1 cycle after the `core_done` sample.
- Back-to-back jobs: the next accept is possible in the cycle after the `resp_ready` handshake (IDLE).
- Reset mid-job: the job is dropped with no response; the core is reset via `core_reset`.
- `req_valid` deasserting before grant is legal; no job is recorded.

## Structure
- Package `aes_sched_pkg`: state enum, `CHUNKS`=16, `CHUNK_W`=16, `SHARE_W`=128, `PRNG_W`=19, LFSR tap mask.
- Sub-module `prng_lfsr19` (seed/reseed/shift); FSM, arbiter and serializer stay in the top.

## Test plan
- Single job, port 0, all-zero shares with real `full_AES` -> `resp_id`=0, `resp_err`=0, and `resp_data[255:128]^resp_data[127:0]` = 128'h66E94BD4EF8A2C3B884CFA59CA342B2E.
- Both ports valid for 3 jobs each -> grant order 0,1,0,1,0,1; `req_ready` is never high on both ports.
- Stub core never raises done, TIMEOUT=20 -> `resp_err`=1, `resp_data`=0, one-cycle `core_reset` pulse 20 cycles after WAIT entry; the next job completes normally.
- Serializer check: pt = 256'h0001_0002_..._0010 -> `core_pt` = 16'h0001..16'h0010 on cycles A+2..A+17, with `core_go` only on A+1.
- Response backpressure: `resp_ready` low 7 cycles -> outputs stable; no new `req_ready` until the handshake.
- `reseed_valid` with `seed_in`=0 -> LFSR reloads SEED; reset asserted during LOAD -> all outputs return to reset values asynchronously.
